// File: rtl/sram_like_mem_slave.sv
// ---------------------------------------------------------------------------
// sram_like_mem_slave
//   Responder end of the SRAM-like req/addr_ok/data_ok interface. It accepts
//   one transaction at a time, adds a configurable address and data latency,
//   and serves word reads and byte/half/word writes from an internal
//   word-addressed array. It is used as the memory model behind the data
//   cache and as the uncached-path target.
//
// Parameters
//   AW        word-address width, depth = 1<<AW words of 32 bits
//   ADDR_LAT  cycles req is held before addr_ok (0 = same cycle as req)
//   DATA_LAT  cycles from the addr handshake to data_ok (min 1)
//   INIT_FILE image name; contents are undefined until written
//
// Ports
//   i_clk      clock, all logic on posedge
//   i_resetn   synchronous reset, active low
//   i_req      initiator request
//   i_wr       1 = write, 0 = read
//   i_size     00 byte, 01 half, 1x word
//   i_addr     byte address
//   i_wdata    write data, byte lanes aligned to i_addr[1:0]
//   o_rdata    read data, valid in the data_ok cycle, held otherwise
//   o_addr_ok  address handshake (i_req & o_addr_ok = accepted)
//   o_data_ok  one-cycle completion pulse
// ---------------------------------------------------------------------------
module sram_like_mem_slave #(
   parameter int    AW        = 12,
   parameter int    ADDR_LAT  = 1,
   parameter int    DATA_LAT  = 2,
   parameter string INIT_FILE = ""
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_req,
   input  logic        i_wr,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_addr_ok,
   output logic        o_data_ok
);

   localparam logic [7:0] LP_ALAT = 8'(ADDR_LAT);
   localparam logic [7:0] LP_DEND = 8'(DATA_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_AWAIT, S_DWAIT, S_RESP} state_t;

   state_t        r_state;
   logic [7:0]    r_cnt;
   logic          r_wr;
   logic [AW-1:0] r_idx;
   logic [3:0]    r_mask;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_data_ok;

   logic [31:0]   r_mem [0:(1<<AW)-1];

   logic [3:0]    w_mask;
   logic [AW-1:0] w_acc_idx;
   logic [31:0]   w_acc_word;
   logic [31:0]   w_lat_word;
   logic [31:0]   w_mask32;
   logic          w_addr_ok;
   logic          w_unused;

   // Upper address bits alias onto the array.
   assign w_unused   = ^i_addr[31:AW+2];
   assign w_acc_idx  = i_addr[AW+1:2];
   assign w_acc_word = r_mem[w_acc_idx];
   assign w_lat_word = r_mem[r_idx];
   assign w_mask32   = {{8{r_mask[3]}}, {8{r_mask[2]}}, {8{r_mask[1]}}, {8{r_mask[0]}}};

   // Misaligned half/word ignore the low address bits outside their lane.
   always_comb begin
      w_mask = 4'b1111;
      case (i_size)
         2'b00:   w_mask = 4'b0001 << i_addr[1:0];
         2'b01:   w_mask = i_addr[1] ? 4'b1100 : 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   // Handshake depends only on state, counter and req.
   assign w_addr_ok = i_req &&
                      (((r_state == S_IDLE) && (ADDR_LAT == 0)) ||
                       ((r_state == S_AWAIT) && (r_cnt == LP_ALAT)));

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_rdata   <= 32'd0;
         r_data_ok <= 1'b0;
         r_wr      <= 1'b0;
         r_idx     <= '0;
         r_mask    <= 4'd0;
         r_wdata   <= 32'd0;
      end else begin
         r_data_ok <= 1'b0;
         case (r_state)
            S_IDLE, S_AWAIT: begin
               if (w_addr_ok) begin
                  r_wr    <= i_wr;
                  r_idx   <= w_acc_idx;
                  r_mask  <= w_mask;
                  r_wdata <= i_wdata;
                  r_cnt   <= 8'd1;
                  if (DATA_LAT <= 1) begin
                     // No DWAIT: read the word straight from the request address.
                     r_state   <= S_RESP;
                     r_data_ok <= 1'b1;
                     r_rdata   <= i_wr ? 32'd0 : w_acc_word;
                  end else begin
                     r_state <= S_DWAIT;
                  end
               end else if (r_state == S_IDLE) begin
                  if (i_req) begin
                     r_cnt   <= 8'd1;
                     r_state <= S_AWAIT;
                  end
               end else if (!i_req) begin
                  // Initiator abandoned the request: no response.
                  r_state <= S_IDLE;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DWAIT: begin
               if (r_cnt >= LP_DEND) begin
                  r_state   <= S_RESP;
                  r_data_ok <= 1'b1;
                  r_rdata   <= r_wr ? 32'd0 : w_lat_word;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 8'd0;
            end
         endcase
      end
   end

   // Write commits on the edge ending RESP; a reset on that edge drops it.
   always_ff @(posedge i_clk) begin
      if (i_resetn && (r_state == S_RESP) && r_wr)
         r_mem[r_idx] <= (r_mem[r_idx] & ~w_mask32) | (r_wdata & w_mask32);
   end

   assign o_addr_ok = w_addr_ok;
   assign o_data_ok = r_data_ok;
   assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_sram_like_mem_slave.sv
module tb_sram_like_mem_slave;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_a, req_b, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [31:0] rdata_a, rdata_b;
   logic        aok_a, aok_b, dok_a, dok_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // DUT A: default latencies. DUT B: zero address latency, one-cycle data.
   sram_like_mem_slave #(.AW(12), .ADDR_LAT(1), .DATA_LAT(2), .INIT_FILE("")) u_a (
      .i_clk(clk), .i_resetn(resetn), .i_req(req_a), .i_wr(wr), .i_size(size),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_a), .o_addr_ok(aok_a), .o_data_ok(dok_a));

   sram_like_mem_slave #(.AW(12), .ADDR_LAT(0), .DATA_LAT(1), .INIT_FILE("")) u_b (
      .i_clk(clk), .i_resetn(resetn), .i_req(req_b), .i_wr(wr), .i_size(size),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_b), .o_addr_ok(aok_b), .o_data_ok(dok_b));

   // Issue one transaction on DUT d starting at posedge+1 (cycle 0).
   // Returns handshake and completion cycle numbers, the number of addr_ok
   // assertions seen after the handshake, and rdata in the data_ok cycle.
   // hold keeps req high (with scrambled inputs) after the handshake.
   task automatic run_txn(input int d, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          output int t_aok, output int t_dok, output int n_bad,
                          output logic [31:0] rd);
      int cyc;
      logic ao, dk;
      t_aok = -1; t_dok = -1; n_bad = 0; rd = 32'hx; cyc = 0;
      wr = w; size = sz; addr = a; wdata = wd;
      if (d == 0) req_a = 1'b1; else req_b = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         ao = (d == 0) ? aok_a : aok_b;
         if (ao) begin t_aok = cyc; break; end
         @(posedge clk); #1; cyc++;
      end
      if (t_aok < 0) begin
         errors++;
         $display("FAIL addr_ok_timeout: no handshake within 20 cycles");
      end else begin
         @(posedge clk); #1; cyc++;
         wr = ~w; addr = ~a; wdata = ~wd;
         if (!hold) begin req_a = 1'b0; req_b = 1'b0; end
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ao = (d == 0) ? aok_a : aok_b;
            dk = (d == 0) ? dok_a : dok_b;
            if (ao) n_bad++;
            if (dk) begin t_dok = cyc; rd = (d == 0) ? rdata_a : rdata_b; break; end
            @(posedge clk); #1; cyc++;
         end
         if (t_dok < 0) begin
            errors++;
            $display("FAIL data_ok_timeout: no data_ok within 20 cycles");
         end
         @(posedge clk); #1;
      end
      req_a = 1'b0; req_b = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; req_a = 1'b0; req_b = 1'b0;
      wr = 1'b0; size = 2'b10; addr = 32'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (aok_a !== 1'b0) begin errors++; $display("FAIL rst_aok_a: got %b want 0", aok_a); end
      checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL rst_dok_a: got %b want 0", dok_a); end
      checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL rst_rdata_a: got %h want 0", rdata_a); end
      checks++; if (aok_b !== 1'b0) begin errors++; $display("FAIL rst_aok_b: got %b want 0", aok_b); end
      checks++; if (dok_b !== 1'b0) begin errors++; $display("FAIL rst_dok_b: got %b want 0", dok_b); end
      checks++; if (rdata_b !== 32'd0) begin errors++; $display("FAIL rst_rdata_b: got %h want 0", rdata_b); end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_word_rw();
      int ta, td, nb; logic [31:0] rd;
      run_txn(0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 1'b0, ta, td, nb, rd);
      checks++; if (ta !== 1) begin errors++; $display("FAIL wr_aok_cycle: got %0d want 1", ta); end
      checks++; if (td !== 3) begin errors++; $display("FAIL wr_dok_cycle: got %0d want 3", td); end
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
      run_txn(0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (td !== 3) begin errors++; $display("FAIL rd_dok_cycle: got %0d want 3", td); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_word: got %h want deadbeef", rd); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h want deadbeef", rdata_a); end
      checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL dok_single: got %b want 0", dok_a); end
      @(posedge clk); #1;
   endtask

   task automatic test_subword();
      int ta, td, nb; logic [31:0] rd;
      run_txn(0, 1'b1, 2'b10, 32'h40, 32'h11223344, 1'b0, ta, td, nb, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sw_wr_rdata: got %h want 0", rd); end
      run_txn(0, 1'b1, 2'b00, 32'h42, 32'h00AA0000, 1'b0, ta, td, nb, rd);
      run_txn(0, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL sb_merge: got %h want 11aa3344", rd); end
      run_txn(0, 1'b1, 2'b01, 32'h40, 32'h0000BBBB, 1'b0, ta, td, nb, rd);
      run_txn(0, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (rd !== 32'h11AABBBB) begin errors++; $display("FAIL sh_merge: got %h want 11aabbbb", rd); end
      // misaligned half at 0x43 lands in the upper lane
      run_txn(0, 1'b1, 2'b01, 32'h43, 32'hCCCC0000, 1'b0, ta, td, nb, rd);
      run_txn(0, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (rd !== 32'hCCCCBBBB) begin errors++; $display("FAIL sh_misalign: got %h want ccccbbbb", rd); end
   endtask

   task automatic test_back_to_back();
      int ta, td, nb; logic [31:0] rd;
      run_txn(0, 1'b1, 2'b10, 32'h300, 32'h0BADF00D, 1'b0, ta, td, nb, rd);
      run_txn(0, 1'b1, 2'b10, 32'h200, 32'hA5A5A5A5, 1'b1, ta, td, nb, rd);
      checks++; if (td !== 3) begin errors++; $display("FAIL b2b_wr_dok: got %0d want 3", td); end
      checks++; if (nb !== 0) begin errors++; $display("FAIL b2b_wr_busy_aok: got %0d want 0", nb); end
      run_txn(0, 1'b0, 2'b10, 32'h300, 32'h0, 1'b1, ta, td, nb, rd);
      checks++; if (ta !== 1) begin errors++; $display("FAIL b2b_rd_aok: got %0d want 1", ta); end
      checks++; if (nb !== 0) begin errors++; $display("FAIL b2b_rd_busy_aok: got %0d want 0", nb); end
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_rd_data: got %h want 0badf00d", rd); end
   endtask

   task automatic test_zero_lat();
      int ta, td, nb; logic [31:0] rd;
      run_txn(1, 1'b1, 2'b10, 32'h20, 32'h87654321, 1'b1, ta, td, nb, rd);
      checks++; if (ta !== 0) begin errors++; $display("FAIL zl_aok_cycle: got %0d want 0", ta); end
      checks++; if (td !== 1) begin errors++; $display("FAIL zl_dok_cycle: got %0d want 1", td); end
      checks++; if (nb !== 0) begin errors++; $display("FAIL zl_aok_in_resp: got %0d want 0", nb); end
      run_txn(1, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (rd !== 32'h87654321) begin errors++; $display("FAIL zl_rd_data: got %h want 87654321", rd); end
   endtask

   task automatic test_reset_in_flight();
      int ta, td, nb, seen; logic [31:0] rd;
      run_txn(0, 1'b1, 2'b10, 32'h10, 32'hCAFEF00D, 1'b0, ta, td, nb, rd);
      run_txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, ta, td, nb, rd);
      // cycle 0 request, cycle 1 handshake, cycle 2 DWAIT: reset there
      wr = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h55; req_a = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (aok_a !== 1'b1) begin errors++; $display("FAIL rif_aok: got %b want 1", aok_a); end
      @(posedge clk); #1;
      req_a = 1'b0; resetn = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL rif_dok: got %b want 0", dok_a); end
      checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL rif_rdata: got %h want 0", rdata_a); end
      @(posedge clk); #1;
      resetn = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (dok_a) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rif_late_dok: got %0d want 0", seen); end
      @(posedge clk); #1;
      run_txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rif_mem_kept: got %h want cafef00d", rd); end
   endtask

   task automatic test_alias_abort();
      int ta, td, nb, seen_a, seen_d; logic [31:0] rd;
      run_txn(0, 1'b1, 2'b10, (32'd1 << 14) + 32'h8, 32'h12345678, 1'b0, ta, td, nb, rd);
      run_txn(0, 1'b0, 2'b10, 32'h8, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL alias: got %h want 12345678", rd); end
      // request in cycle 0 only, withdrawn before the handshake cycle
      wr = 1'b1; size = 2'b10; addr = 32'h8; wdata = 32'hFFFFFFFF; req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0;
      seen_a = 0; seen_d = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (aok_a) seen_a++;
         if (dok_a) seen_d++;
         @(posedge clk); #1;
      end
      checks++; if (seen_a !== 0) begin errors++; $display("FAIL abort_aok: got %0d want 0", seen_a); end
      checks++; if (seen_d !== 0) begin errors++; $display("FAIL abort_dok: got %0d want 0", seen_d); end
      run_txn(0, 1'b0, 2'b10, 32'h8, 32'h0, 1'b0, ta, td, nb, rd);
      checks++; if (ta !== 1) begin errors++; $display("FAIL abort_next_aok: got %0d want 1", ta); end
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_mem: got %h want 12345678", rd); end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_subword();
      test_back_to_back();
      test_zero_lat();
      test_reset_in_flight();
      test_alias_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
